// File: rtl/cell_sweep_checker.sv
// Exhaustive truth-table sweep of a combinational cell: drives every input
// vector (binary or Gray order), samples ZN after a settle window, tallies mismatches.
module cell_sweep_checker #(
    parameter int                  N_IN   = 6,
    parameter int                  SETTLE = 2,
    // OAI222, STIM[5:4]=A, [3:2]=B, [1:0]=C: ZN=1 iff some input pair is all-zero (37 ones)
    parameter logic [2**N_IN-1:0]  TRUTH  = 64'h111F_111F_111F_FFFF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic              mode_i,
    input  logic              zn_i,
    output logic [N_IN-1:0]   stim_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              pass_o,
    output logic [N_IN:0]     err_cnt_o,
    output logic              fail_valid_o,
    output logic [N_IN-1:0]   first_fail_o
);

    localparam int            NV       = 2**N_IN;
    localparam logic [N_IN:0] IDX_LAST = (N_IN+1)'(NV - 1);
    localparam logic [N_IN:0] ERR_MAX  = (N_IN+1)'(NV);
    localparam logic [7:0]    SET_LAST = 8'(SETTLE);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [N_IN:0]   idx_q, idx_d;
    logic [7:0]      settle_q, settle_d;
    logic            mode_q, mode_d;
    logic [N_IN-1:0] stim_q, stim_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            pass_q, pass_d;
    logic [N_IN:0]   err_q, err_d;
    logic            fv_q, fv_d;
    logic [N_IN-1:0] ff_q, ff_d;
    logic            sample_s;
    logic            mismatch_s;

    function automatic logic [N_IN-1:0] vec_of(input logic [N_IN:0] idx, input logic gray);
        logic [N_IN-1:0] b;
        b = idx[N_IN-1:0];
        return gray ? (b ^ (b >> 1)) : b;
    endfunction

    assign sample_s   = (state_q == S_RUN) && !abort_i && (settle_q == SET_LAST);
    assign mismatch_s = sample_s && (zn_i != TRUTH[stim_q]);

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_FIN: begin
                if (start_i) begin
                    state_d = S_RUN;
                end else begin
                    state_d = state_q;
                end
            end
            S_RUN: begin
                if (abort_i) begin
                    state_d = S_IDLE;
                end else if (sample_s && (idx_q == IDX_LAST)) begin
                    state_d = S_FIN;
                end else begin
                    state_d = S_RUN;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Next values of counters and registered outputs
    always_comb begin
        idx_d    = idx_q;
        settle_d = settle_q;
        mode_d   = mode_q;
        stim_d   = stim_q;
        done_d   = done_q;
        pass_d   = pass_q;
        err_d    = err_q;
        fv_d     = fv_q;
        ff_d     = ff_q;
        case (state_q)
            S_IDLE, S_FIN: begin
                if (start_i) begin
                    idx_d    = {(N_IN+1){1'b0}};
                    settle_d = 8'd0;
                    mode_d   = mode_i;
                    stim_d   = {N_IN{1'b0}};
                    done_d   = 1'b0;
                    pass_d   = 1'b0;
                    err_d    = {(N_IN+1){1'b0}};
                    fv_d     = 1'b0;
                end else begin
                    idx_d = idx_q;
                end
            end
            S_RUN: begin
                if (abort_i) begin
                    idx_d    = {(N_IN+1){1'b0}};
                    settle_d = 8'd0;
                    stim_d   = {N_IN{1'b0}};
                    done_d   = 1'b0;
                    pass_d   = 1'b0;
                end else if (sample_s) begin
                    if (mismatch_s && (err_q != ERR_MAX)) begin
                        err_d = err_q + 1'b1;
                    end else begin
                        err_d = err_q;
                    end
                    if (mismatch_s && !fv_q) begin
                        ff_d = stim_q;
                        fv_d = 1'b1;
                    end else begin
                        ff_d = ff_q;
                    end
                    settle_d = 8'd0;
                    if (idx_q == IDX_LAST) begin
                        idx_d  = {(N_IN+1){1'b0}};
                        stim_d = {N_IN{1'b0}};
                        done_d = 1'b1;
                        pass_d = (err_d == {(N_IN+1){1'b0}});
                    end else begin
                        idx_d  = idx_q + 1'b1;
                        stim_d = vec_of(idx_q + 1'b1, mode_q);
                    end
                end else begin
                    settle_d = settle_q + 8'd1;
                end
            end
            default: begin
                idx_d = {(N_IN+1){1'b0}};
            end
        endcase
        busy_d = (state_d == S_RUN);
    end

    // Datapath and output registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            idx_q    <= {(N_IN+1){1'b0}};
            settle_q <= 8'd0;
            mode_q   <= 1'b0;
            stim_q   <= {N_IN{1'b0}};
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            err_q    <= {(N_IN+1){1'b0}};
            fv_q     <= 1'b0;
            ff_q     <= {N_IN{1'b0}};
        end else begin
            idx_q    <= idx_d;
            settle_q <= settle_d;
            mode_q   <= mode_d;
            stim_q   <= stim_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
            err_q    <= err_d;
            fv_q     <= fv_d;
            ff_q     <= ff_d;
        end
    end

    assign stim_o       = stim_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign pass_o       = pass_q;
    assign err_cnt_o    = err_q;
    assign fail_valid_o = fv_q;
    assign first_fail_o = ff_q;

endmodule

// File: tb/tb_cell_sweep_checker.sv
// Randomized sweeps of cell_sweep_checker against an OAI222 reference and a
// sweep-level model of expected stimulus order, error tally and first failure.
module tb_cell_sweep_checker;

    localparam int NV   = 64;
    localparam int HOLD = 3;
    localparam int LEN  = NV * HOLD;

    logic       clk_i = 1'b0;
    logic       rst_i, start_i, abort_i, mode_i, zn_i;
    logic [5:0] stim_o, first_fail_o;
    logic       busy_o, done_o, pass_o, fail_valid_o;
    logic [6:0] err_cnt_o;

    int fault_sel;
    bit flip [NV];
    int n_chk;
    int n_err;

    cell_sweep_checker dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .abort_i(abort_i),
        .mode_i(mode_i), .zn_i(zn_i), .stim_o(stim_o), .busy_o(busy_o),
        .done_o(done_o), .pass_o(pass_o), .err_cnt_o(err_cnt_o),
        .fail_valid_o(fail_valid_o), .first_fail_o(first_fail_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic bit oai222(input logic [5:0] v);
        return !(((v[5] | v[4]) & (v[3] | v[2]) & (v[1] | v[0])));
    endfunction

    function automatic bit dut_zn(input logic [5:0] v, input int f);
        case (f)
            1:       return 1'b0;
            2:       return (v == 6'h3F) ? 1'b1 : oai222(v);
            3:       return oai222(v) ^ flip[v];
            default: return oai222(v);
        endcase
    endfunction

    function automatic logic [5:0] vec(input int k, input logic m);
        logic [5:0] b;
        b = 6'(k);
        return m ? (b ^ (b >> 1)) : b;
    endfunction

    assign zn_i = dut_zn(stim_o, fault_sel);

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Expected tally over all vectors whose sample edge precedes limit_edge
    task automatic expect_tally(input logic m, input int f, input int limit_edge,
                                output int e, output bit fv, output logic [5:0] ff);
        e = 0; fv = 1'b0; ff = 6'd0;
        for (int k = 0; k < NV; k++) begin
            if ((k + 1) * HOLD < limit_edge && dut_zn(vec(k, m), f) != oai222(vec(k, m))) begin
                e++;
                if (!fv) begin
                    fv = 1'b1;
                    ff = vec(k, m);
                end
            end
        end
    endtask

    task automatic do_sweep(input logic m, input int f, input int abort_t, input bit poke_start);
        int e; bit fv; logic [5:0] ff; logic [5:0] prev;
        @(negedge clk_i);
        fault_sel = f; mode_i = m; start_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        start_i = 1'b0; mode_i = ~m;
        prev = 6'd0;
        for (int t = 0; t < LEN; t++) begin
            check_eq("stim", 32'(stim_o), 32'(vec(t / HOLD, m)));
            check_eq("busy", 32'(busy_o), 32'd1);
            if (m && t > 0 && (t % HOLD) == 0)
                check_eq("gray_step", 32'($countones(stim_o ^ prev)), 32'd1);
            prev = stim_o;
            abort_i = (abort_t == t + 1);
            start_i = poke_start && (t == 40);
            @(posedge clk_i);
            @(negedge clk_i);
            abort_i = 1'b0; start_i = 1'b0;
            if (abort_t == t + 1) begin
                expect_tally(m, f, abort_t, e, fv, ff);
                check_eq("abort_stim", 32'(stim_o), 32'd0);
                check_eq("abort_busy", 32'(busy_o), 32'd0);
                check_eq("abort_done", 32'(done_o), 32'd0);
                check_eq("abort_pass", 32'(pass_o), 32'd0);
                check_eq("abort_err", 32'(err_cnt_o), 32'(e));
                check_eq("abort_fv", 32'(fail_valid_o), 32'(fv));
                if (fv) check_eq("abort_ff", 32'(first_fail_o), 32'(ff));
                return;
            end
        end
        expect_tally(m, f, LEN + 1, e, fv, ff);
        for (int h = 0; h < 3; h++) begin
            check_eq("fin_done", 32'(done_o), 32'd1);
            check_eq("fin_busy", 32'(busy_o), 32'd0);
            check_eq("fin_stim", 32'(stim_o), 32'd0);
            check_eq("fin_pass", 32'(pass_o), 32'(e == 0));
            check_eq("fin_err", 32'(err_cnt_o), 32'(e));
            check_eq("fin_fv", 32'(fail_valid_o), 32'(fv));
            if (fv) check_eq("fin_ff", 32'(first_fail_o), 32'(ff));
            @(negedge clk_i);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_stim"}, 32'(stim_o), 32'd0);
        check_eq({tag, "_busy"}, 32'(busy_o), 32'd0);
        check_eq({tag, "_done"}, 32'(done_o), 32'd0);
        check_eq({tag, "_pass"}, 32'(pass_o), 32'd0);
        check_eq({tag, "_err"}, 32'(err_cnt_o), 32'd0);
        check_eq({tag, "_fv"}, 32'(fail_valid_o), 32'd0);
        check_eq({tag, "_ff"}, 32'(first_fail_o), 32'd0);
    endtask

    initial begin
        n_chk = 0; n_err = 0; fault_sel = 0;
        rst_i = 1'b1; start_i = 1'b0; abort_i = 1'b0; mode_i = 1'b0;
        for (int i = 0; i < NV; i++) flip[i] = 1'b0;
        #1;
        check_all_zero("rst");
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;

        do_sweep(1'b0, 0, -1, 1'b0);   // clean binary sweep
        do_sweep(1'b0, 1, -1, 1'b0);   // ZN stuck at 0
        do_sweep(1'b1, 0, -1, 1'b1);   // Gray, START poked mid-run
        do_sweep(1'b0, 2, -1, 1'b0);   // only vector 63 wrong
        do_sweep(1'b0, 1, 50, 1'b0);   // abort at E0+50
        do_sweep(1'b0, 0, -1, 1'b0);   // restart after abort

        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < NV; i++) flip[i] = ($urandom_range(0, 7) == 0);
            do_sweep(1'($urandom_range(0, 1)), 3, -1, 1'b0);
        end
        do_sweep(1'b1, 3, 3 * $urandom_range(2, 60) + 1, 1'b0);

        // asynchronous reset between edges, mid-sweep
        @(negedge clk_i);
        fault_sel = 1; mode_i = 1'b0; start_i = 1'b1;
        @(posedge clk_i);
        #1 start_i = 1'b0;
        repeat (20) @(posedge clk_i);
        #2 rst_i = 1'b1;
        #1 check_all_zero("async_rst");
        #1 rst_i = 1'b0;
        do_sweep(1'b0, 0, -1, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
